// File: rtl/wb_exc_commit.sv
// wb_exc_commit: writeback-stage commit unit for the 5-stage MIPS core.
// Latches the retiring instruction from MEM and writes the GPR file. It
// resolves the final exception/interrupt for that instruction and drives the
// packed CP0 write bus. It also raises the one-cycle pipeline flush with its
// redirect PC for exceptions and ERET.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ms_to_ws_valid/ws_allowin  MEM->WB handshake (WB never stalls)
//   ms_*                       retiring instruction fields from MEM
//   c0_rdata/c0_epc/c0_status_*/c0_cause_ip  CP0 state inputs
//   c0_bus                     {ex, excode, badvaddr, bd, pc, mtc0_we, waddr,
//                               wdata, eret_flush} to CP0
//   c0_raddr                   latched CP0 read address
//   rf_we/rf_waddr/rf_wdata    GPR write port
//   flush/flush_pc             pipeline kill and redirect target
module wb_exc_commit #(
  parameter logic [31:0] EX_ENTRY = 32'hbfc00380,
  localparam int unsigned WB_TO_CP0_REGISTER_BUS_WD = 110
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 ms_to_ws_valid,
  output logic                                 ws_allowin,
  input  logic [31:0]                          ms_pc,
  input  logic                                 ms_gr_we,
  input  logic [4:0]                           ms_dest,
  input  logic [31:0]                          ms_result,
  input  logic [5:0]                           ms_ex_flags,
  input  logic                                 ms_is_store,
  input  logic [31:0]                          ms_badvaddr,
  input  logic                                 ms_bd,
  input  logic                                 ms_mtc0,
  input  logic                                 ms_mfc0,
  input  logic                                 ms_eret,
  input  logic [4:0]                           ms_c0_addr,
  input  logic [31:0]                          ms_c0_wdata,
  input  logic [31:0]                          c0_rdata,
  input  logic [31:0]                          c0_epc,
  input  logic                                 c0_status_ie,
  input  logic                                 c0_status_exl,
  input  logic [7:0]                           c0_status_im,
  input  logic [7:0]                           c0_cause_ip,
  output logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] c0_bus,
  output logic [4:0]                           c0_raddr,
  output logic                                 rf_we,
  output logic [4:0]                           rf_waddr,
  output logic [31:0]                          rf_wdata,
  output logic                                 flush,
  output logic [31:0]                          flush_pc
);

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  logic        r_ws_valid;
  logic [31:0] r_ws_pc;
  logic        r_ws_gr_we;
  logic [4:0]  r_ws_dest;
  logic [31:0] r_ws_result;
  logic [5:0]  r_ws_ex_flags;
  logic        r_ws_is_store;
  logic [31:0] r_ws_badvaddr;
  logic        r_ws_bd;
  logic        r_ws_mtc0;
  logic        r_ws_mfc0;
  logic        r_ws_eret;
  logic [4:0]  r_ws_c0_addr;
  logic [31:0] r_ws_c0_wdata;

  logic        w_int_pending;
  logic        w_ex;
  logic [4:0]  w_excode;
  logic [31:0] w_badvaddr;
  logic        w_mtc0_we;
  logic        w_eret_flush;

  assign ws_allowin = 1'b1;

  // WB stage register; an instruction arriving during a flush is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws_valid    <= 1'b0;
      r_ws_pc       <= '0;
      r_ws_gr_we    <= 1'b0;
      r_ws_dest     <= '0;
      r_ws_result   <= '0;
      r_ws_ex_flags <= '0;
      r_ws_is_store <= 1'b0;
      r_ws_badvaddr <= '0;
      r_ws_bd       <= 1'b0;
      r_ws_mtc0     <= 1'b0;
      r_ws_mfc0     <= 1'b0;
      r_ws_eret     <= 1'b0;
      r_ws_c0_addr  <= '0;
      r_ws_c0_wdata <= '0;
    end else begin
      if (ws_allowin) begin
        r_ws_valid <= ms_to_ws_valid & ~flush;
      end
      if (ws_allowin && ms_to_ws_valid) begin
        r_ws_pc       <= ms_pc;
        r_ws_gr_we    <= ms_gr_we;
        r_ws_dest     <= ms_dest;
        r_ws_result   <= ms_result;
        r_ws_ex_flags <= ms_ex_flags;
        r_ws_is_store <= ms_is_store;
        r_ws_badvaddr <= ms_badvaddr;
        r_ws_bd       <= ms_bd;
        r_ws_mtc0     <= ms_mtc0;
        r_ws_mfc0     <= ms_mfc0;
        r_ws_eret     <= ms_eret;
        r_ws_c0_addr  <= ms_c0_addr;
        r_ws_c0_wdata <= ms_c0_wdata;
      end
    end
  end

  // Interrupts attach to whatever valid instruction sits in WB.
  assign w_int_pending = c0_status_ie & ~c0_status_exl & (|(c0_status_im & c0_cause_ip));
  assign w_ex          = r_ws_valid & (w_int_pending | (|r_ws_ex_flags));

  // Priority resolve of the exception code and faulting address.
  always_comb begin
    w_excode   = '0;
    w_badvaddr = '0;
    if (w_ex) begin
      if (w_int_pending) begin
        w_excode = EXC_INT;
      end else if (r_ws_ex_flags[5]) begin
        w_excode   = EXC_ADEL;
        w_badvaddr = r_ws_pc;
      end else if (r_ws_ex_flags[4]) begin
        w_excode = EXC_RI;
      end else if (r_ws_ex_flags[3]) begin
        w_excode = EXC_OV;
      end else if (r_ws_ex_flags[2]) begin
        w_excode = EXC_SYS;
      end else if (r_ws_ex_flags[1]) begin
        w_excode = EXC_BP;
      end else begin
        w_excode   = r_ws_is_store ? EXC_ADES : EXC_ADEL;
        w_badvaddr = r_ws_badvaddr;
      end
    end
  end

  // An exception suppresses every architectural side effect of the instruction.
  assign w_mtc0_we    = r_ws_valid & r_ws_mtc0 & ~w_ex;
  assign w_eret_flush = r_ws_valid & r_ws_eret & ~w_ex;

  assign rf_we    = r_ws_valid & r_ws_gr_we & ~w_ex;
  assign rf_waddr = r_ws_dest;
  assign rf_wdata = r_ws_mfc0 ? c0_rdata : r_ws_result;
  assign c0_raddr = r_ws_c0_addr;

  // EPC is only the target on ERET; the vector is presented otherwise.
  assign flush    = w_ex | w_eret_flush;
  assign flush_pc = (w_eret_flush && !w_ex) ? c0_epc : EX_ENTRY;

  // pc is raw; CP0 applies the delay-slot adjustment from bd.
  assign c0_bus = {w_ex, w_excode, w_badvaddr, r_ws_bd, r_ws_pc,
                   w_mtc0_we, r_ws_c0_addr, r_ws_c0_wdata, w_eret_flush};

endmodule

// File: tb/tb_wb_exc_commit.sv
// Directed bench for wb_exc_commit with an expected-result queue.
module tb_wb_exc_commit;

  localparam int unsigned BW = 110;
  localparam logic [31:0] EXV = 32'hbfc00380;
  localparam logic [BW-1:0] FULL    = '1;
  localparam logic [BW-1:0] EN_MASK = (BW'(1) << 109) | (BW'(1) << 38) | BW'(1);

  logic          clk;
  logic          reset;
  logic          ms_to_ws_valid;
  logic          ws_allowin;
  logic [31:0]   ms_pc;
  logic          ms_gr_we;
  logic [4:0]    ms_dest;
  logic [31:0]   ms_result;
  logic [5:0]    ms_ex_flags;
  logic          ms_is_store;
  logic [31:0]   ms_badvaddr;
  logic          ms_bd;
  logic          ms_mtc0;
  logic          ms_mfc0;
  logic          ms_eret;
  logic [4:0]    ms_c0_addr;
  logic [31:0]   ms_c0_wdata;
  logic [31:0]   c0_rdata;
  logic [31:0]   c0_epc;
  logic          c0_status_ie;
  logic          c0_status_exl;
  logic [7:0]    c0_status_im;
  logic [7:0]    c0_cause_ip;
  logic [BW-1:0] c0_bus;
  logic [4:0]    c0_raddr;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          flush;
  logic [31:0]   flush_pc;

  wb_exc_commit #(.EX_ENTRY(EXV)) dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_result(ms_result), .ms_ex_flags(ms_ex_flags),
    .ms_is_store(ms_is_store), .ms_badvaddr(ms_badvaddr), .ms_bd(ms_bd),
    .ms_mtc0(ms_mtc0), .ms_mfc0(ms_mfc0), .ms_eret(ms_eret),
    .ms_c0_addr(ms_c0_addr), .ms_c0_wdata(ms_c0_wdata),
    .c0_rdata(c0_rdata), .c0_epc(c0_epc),
    .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl),
    .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip),
    .c0_bus(c0_bus), .c0_raddr(c0_raddr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush(flush), .flush_pc(flush_pc)
  );

  typedef struct {
    string         tag;
    logic          rf_we;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic          flush;
    logic [31:0]   flush_pc;
    logic [BW-1:0] bus;
    logic [BW-1:0] mask;
    logic [4:0]    raddr;
    logic          full;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] mkbus(input logic ex, input logic [4:0] code,
      input logic [31:0] bva, input logic bd, input logic [31:0] pc,
      input logic mtc0_we, input logic [4:0] wa, input logic [31:0] wd,
      input logic eret);
    return {ex, code, bva, bd, pc, mtc0_we, wa, wd, eret};
  endfunction

  task automatic push(input string tag, input logic we, input logic [4:0] wa,
      input logic [31:0] wd, input logic fl, input logic [31:0] fpc,
      input logic [BW-1:0] bus, input logic [4:0] ra);
    exp_t e;
    e.tag = tag; e.rf_we = we; e.waddr = wa; e.wdata = wd; e.flush = fl;
    e.flush_pc = fpc; e.bus = bus; e.mask = FULL; e.raddr = ra; e.full = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_reset(input string tag);
    exp_t e;
    e.tag = tag; e.rf_we = 1'b0; e.waddr = '0; e.wdata = '0; e.flush = 1'b0;
    e.flush_pc = EXV; e.bus = '0; e.mask = EN_MASK; e.raddr = '0; e.full = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      n_tests++;
      assert (ws_allowin === 1'b1) else begin
        n_fail++; $error("FAIL %s.allowin observed=%b expected=1", e.tag, ws_allowin);
      end
      n_tests++;
      assert (rf_we === e.rf_we) else begin
        n_fail++; $error("FAIL %s.rf_we observed=%b expected=%b", e.tag, rf_we, e.rf_we);
      end
      n_tests++;
      assert (flush === e.flush) else begin
        n_fail++; $error("FAIL %s.flush observed=%b expected=%b", e.tag, flush, e.flush);
      end
      n_tests++;
      assert (flush_pc === e.flush_pc) else begin
        n_fail++; $error("FAIL %s.flush_pc observed=%h expected=%h", e.tag, flush_pc, e.flush_pc);
      end
      n_tests++;
      assert ((c0_bus & e.mask) === (e.bus & e.mask)) else begin
        n_fail++; $error("FAIL %s.c0_bus observed=%h expected=%h", e.tag, c0_bus & e.mask, e.bus & e.mask);
      end
      if (e.full) begin
        n_tests++;
        assert (rf_waddr === e.waddr) else begin
          n_fail++; $error("FAIL %s.rf_waddr observed=%h expected=%h", e.tag, rf_waddr, e.waddr);
        end
        n_tests++;
        assert (rf_wdata === e.wdata) else begin
          n_fail++; $error("FAIL %s.rf_wdata observed=%h expected=%h", e.tag, rf_wdata, e.wdata);
        end
        n_tests++;
        assert (c0_raddr === e.raddr) else begin
          n_fail++; $error("FAIL %s.c0_raddr observed=%h expected=%h", e.tag, c0_raddr, e.raddr);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic ms_clear();
    ms_to_ws_valid = 1'b0; ms_pc = '0; ms_gr_we = 1'b0; ms_dest = '0;
    ms_result = '0; ms_ex_flags = '0; ms_is_store = 1'b0; ms_badvaddr = '0;
    ms_bd = 1'b0; ms_mtc0 = 1'b0; ms_mfc0 = 1'b0; ms_eret = 1'b0;
    ms_c0_addr = '0; ms_c0_wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    ms_clear();
    c0_rdata = '0; c0_epc = '0; c0_status_ie = 1'b0; c0_status_exl = 1'b0;
    c0_status_im = '0; c0_cause_ip = '0;
    repeat (2) @(posedge clk);
    #1;
    push_reset("reset");
    check_out();
    reset = 1'b0;

    // Plain ADD
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'hbfc00000; ms_gr_we = 1'b1;
    ms_dest = 5'd5; ms_result = 32'h1234;
    push("add", 1'b1, 5'd5, 32'h1234, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'hbfc00000, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();

    // Overflow in a delay slot
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'hbfc00100; ms_bd = 1'b1;
    ms_ex_flags = 6'b001000; ms_gr_we = 1'b1; ms_dest = 5'd7; ms_result = 32'h55;
    push("ov", 1'b0, 5'd7, 32'h55, 1'b1, 32'hbfc00380,
         mkbus(1'b1, 5'd12, 32'h0, 1'b1, 32'hbfc00100, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();

    // Instruction arriving during the flush is discarded
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h00400000; ms_gr_we = 1'b1;
    ms_dest = 5'd9; ms_result = 32'h99;
    push("drop", 1'b0, 5'd9, 32'h99, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h00400000, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();

    // Interrupt beats RI
    c0_status_ie = 1'b1; c0_status_im = 8'h80; c0_cause_ip = 8'h80;
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h00400004; ms_ex_flags = 6'b010000;
    ms_gr_we = 1'b1; ms_dest = 5'd3; ms_result = 32'h33;
    push("int_ri", 1'b0, 5'd3, 32'h33, 1'b1, EXV,
         mkbus(1'b1, 5'd0, 32'h0, 1'b0, 32'h00400004, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();

    // Interrupt still pending with no valid instruction: no action
    ms_clear();
    push("int_idle0", 1'b0, 5'd3, 32'h33, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h00400004, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();
    push("int_idle1", 1'b0, 5'd3, 32'h33, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h00400004, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();
    c0_status_ie = 1'b0; c0_status_im = '0; c0_cause_ip = '0;

    // Store address fault
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h00400008; ms_ex_flags = 6'b000001;
    ms_is_store = 1'b1; ms_badvaddr = 32'h1003;
    push("ades", 1'b0, 5'd0, 32'h0, 1'b1, EXV,
         mkbus(1'b1, 5'd5, 32'h1003, 1'b0, 32'h00400008, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();
    ms_clear();
    push("ades_idle", 1'b0, 5'd0, 32'h0, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h00400008, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();

    // Fetch fault outranks a simultaneous data fault
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h2; ms_ex_flags = 6'b100001;
    ms_badvaddr = 32'hdead;
    push("adel_if", 1'b0, 5'd0, 32'h0, 1'b1, EXV,
         mkbus(1'b1, 5'd4, 32'h2, 1'b0, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();
    ms_clear();
    push("adel_idle", 1'b0, 5'd0, 32'h0, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();

    // MTC0 then ERET
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h0040000c; ms_mtc0 = 1'b1;
    ms_c0_addr = 5'd12; ms_c0_wdata = 32'h0000ff01;
    push("mtc0", 1'b0, 5'd0, 32'h0, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0040000c, 1'b1, 5'd12, 32'h0000ff01, 1'b0), 5'd12);
    step();
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h00400010; ms_eret = 1'b1;
    c0_epc = 32'hbfc00200;
    push("eret", 1'b0, 5'd0, 32'h0, 1'b1, 32'hbfc00200,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h00400010, 1'b0, 5'd0, 32'h0, 1'b1), 5'd0);
    step();
    ms_clear();
    push("eret_idle", 1'b0, 5'd0, 32'h0, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h00400010, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();

    // MFC0 takes c0_rdata, not the ALU result
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h00400014; ms_mfc0 = 1'b1;
    ms_gr_we = 1'b1; ms_dest = 5'd8; ms_c0_addr = 5'd12; ms_result = 32'haaaa;
    c0_rdata = 32'h0000ff01;
    push("mfc0", 1'b1, 5'd8, 32'h0000ff01, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h00400014, 1'b0, 5'd12, 32'h0, 1'b0), 5'd12);
    step();

    // Exception suppresses MTC0
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h00400018; ms_mtc0 = 1'b1;
    ms_c0_addr = 5'd12; ms_c0_wdata = 32'h1234; ms_ex_flags = 6'b001000;
    push("mtc0_ov", 1'b0, 5'd0, 32'h0, 1'b1, EXV,
         mkbus(1'b1, 5'd12, 32'h0, 1'b0, 32'h00400018, 1'b0, 5'd12, 32'h1234, 1'b0), 5'd12);
    step();
    ms_clear();
    push("mtc0_ov_idle", 1'b0, 5'd0, 32'h0, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h00400018, 1'b0, 5'd12, 32'h1234, 1'b0), 5'd12);
    step();

    // Exception suppresses ERET; redirect goes to the vector
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h0040001c; ms_eret = 1'b1;
    ms_ex_flags = 6'b000100;
    push("eret_sys", 1'b0, 5'd0, 32'h0, 1'b1, EXV,
         mkbus(1'b1, 5'd8, 32'h0, 1'b0, 32'h0040001c, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();
    ms_clear();
    push("eret_sys_idle", 1'b0, 5'd0, 32'h0, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0040001c, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();

    // Breakpoint in a delay slot
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h00400020; ms_bd = 1'b1;
    ms_ex_flags = 6'b000010;
    push("bp", 1'b0, 5'd0, 32'h0, 1'b1, EXV,
         mkbus(1'b1, 5'd9, 32'h0, 1'b1, 32'h00400020, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();

    // Reset asserted while flush is high
    reset = 1'b1;
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h00400024; ms_gr_we = 1'b1;
    ms_dest = 5'd4; ms_result = 32'h44;
    push_reset("reset_flush");
    step();
    reset = 1'b0;
    ms_clear();
    push_reset("post_reset");
    step();

    // Recovery after reset
    ms_clear(); ms_to_ws_valid = 1'b1; ms_pc = 32'h00400028; ms_gr_we = 1'b1;
    ms_dest = 5'd6; ms_result = 32'h66;
    push("recover", 1'b1, 5'd6, 32'h66, 1'b0, EXV,
         mkbus(1'b0, 5'd0, 32'h0, 1'b0, 32'h00400028, 1'b0, 5'd0, 32'h0, 1'b0), 5'd0);
    step();
    ms_clear();

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++; $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
